// File: rtl/bist_pkg.sv
// Shared types and defaults for the scan-BIST session sequencer.
// Used by the sequencer, its SISR and the future parallel-MISR variant.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SEED,
        SHIFT,
        CAPTURE,
        UNLOAD,
        COMPARE,
        DONE
    } bist_state_e;

    localparam int unsigned BIST_N      = 9;
    localparam int unsigned BIST_M      = 9;
    localparam int unsigned BIST_SIG_W  = 16;
    localparam logic [15:0] BIST_POLY   = 16'h1021;
    localparam logic [15:0] BIST_GOLDEN = 16'hA5C3;

    // Counter width able to hold 0..n; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/bist_sisr.sv
// Single-input signature register compacting the serial CUT response.
// Shifts left; the x^SIG_W term of POLY is implicit.
module bist_sisr
    import bist_pkg::*;
#(
    parameter int unsigned      SIG_W = BIST_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = BIST_POLY
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic             EN,
    input  logic             DIN,
    output logic [SIG_W-1:0] SIG
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (CLR) begin
            sig_d = '0;
        end else if (EN) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, DIN};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign SIG = sig_q;

endmodule

// File: rtl/bist_sequencer.sv
// Scan-BIST session sequencer: seed, M+1 shift/capture rounds, unload,
// then signature compare against GOLDEN.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned      N      = BIST_N,
    parameter int unsigned      M      = BIST_M,
    parameter int unsigned      SIG_W  = BIST_SIG_W,
    parameter logic [SIG_W-1:0] POLY   = BIST_POLY,
    parameter logic [SIG_W-1:0] GOLDEN = BIST_GOLDEN
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             CUT_OUT,
    output logic             SCAN_EN,
    output logic             TPG_LOAD,
    output logic             TPG_EN,
    output logic             RUNNING,
    output logic             BIST_END,
    output logic             PASS,
    output logic [SIG_W-1:0] SIGNATURE
);

    localparam int unsigned SW = cnt_w(N);
    localparam int unsigned PW = cnt_w(M);
    localparam logic [SW-1:0] N_C = SW'(N);
    localparam logic [PW-1:0] M_C = PW'(M);

    bist_state_e state_q, state_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [PW-1:0] pat_q, pat_d;
    logic          pass_q, pass_d;
    logic          sisr_clr, sisr_en;
    logic          shift_last;

    assign shift_last = (shift_q == N_C);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            shift_q <= '0;
            pat_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            pat_q   <= pat_d;
            pass_q  <= pass_d;
        end
    end

    // ARMED is only reachable after START was seen low, so a START held
    // high through reset cannot launch a session.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!START) state_d = ARMED;
            ARMED:   if (START) state_d = SEED;
            SEED:    state_d = SHIFT;
            SHIFT:   if (shift_last) state_d = CAPTURE;
            CAPTURE: state_d = (pat_q == M_C) ? UNLOAD : SHIFT;
            UNLOAD:  if (shift_last) state_d = COMPARE;
            COMPARE: state_d = DONE;
            DONE:    if (!START) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        pat_d   = pat_q;
        pass_d  = pass_q;
        if (state_q == SHIFT || state_q == UNLOAD) begin
            shift_d = shift_last ? '0 : shift_q + SW'(1);
        end
        if (state_q == SEED) begin
            pat_d  = '0;
            pass_d = 1'b0;
        end
        if (state_q == CAPTURE && pat_q != M_C) begin
            pat_d = pat_q + PW'(1);
        end
        if (state_q == COMPARE) begin
            pass_d = (SIGNATURE == GOLDEN);
        end
    end

    always_comb begin
        SCAN_EN  = 1'b0;
        TPG_LOAD = 1'b0;
        TPG_EN   = 1'b0;
        RUNNING  = 1'b0;
        BIST_END = 1'b0;
        sisr_clr = 1'b0;
        sisr_en  = 1'b0;
        unique case (state_q)
            SEED: begin
                TPG_LOAD = 1'b1;
                RUNNING  = 1'b1;
                sisr_clr = 1'b1;
            end
            SHIFT: begin
                SCAN_EN = 1'b1;
                TPG_EN  = 1'b1;
                RUNNING = 1'b1;
                // Pattern 0 unloads uninitialised CUT state; keep it out.
                sisr_en = (pat_q != '0);
            end
            CAPTURE: RUNNING = 1'b1;
            UNLOAD: begin
                SCAN_EN = 1'b1;
                RUNNING = 1'b1;
                sisr_en = 1'b1;
            end
            COMPARE: RUNNING = 1'b1;
            DONE:    BIST_END = 1'b1;
            default: ;
        endcase
    end

    assign PASS = pass_q;

    bist_sisr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_sisr (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (sisr_clr),
        .EN    (sisr_en),
        .DIN   (CUT_OUT),
        .SIG   (SIGNATURE)
    );

endmodule
